// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory access sequencer for the Mini SRC datapath.
// Accepts single load/store requests from the control unit. It sequences
// the MAR/MDR load enables, the MDR input-mux select and the memory strobes.
// It waits on mem_ready, and every wait is bounded by TIMEOUT cycles.
//
// Ports
//   clock      in   system clock, rising edge
//   clear      in   synchronous active-low reset
//   req_rd     in   load request, sampled in IDLE only
//   req_wr     in   store request, sampled in IDLE only (read wins on a tie)
//   mem_ready  in   memory handshake (read data valid / write accepted)
//   MARin      out  MAR load enable
//   MDRin      out  MDR load enable
//   read       out  MDR mux select (1 = Mdatain, 0 = BusMuxOut)
//   mem_rd     out  memory read strobe
//   mem_wr     out  memory write strobe
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse on successful completion
//   err        out  one-cycle pulse on timeout abort
`timescale 1ns/1ps

module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic req_rd,
    input  logic req_wr,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned CNT_W = 8;
    // Last wait-cycle index before aborting; gives exactly TIMEOUT wait cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_MAR    = 3'd1,
        RD_WAIT     = 3'd2,
        RD_CAPTURE  = 3'd3,
        WR_LOAD_MDR = 3'd4,
        WR_WAIT     = 3'd5,
        DONE        = 3'd6,
        ERR         = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             op_rd_q, op_rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic marin_q,  marin_d;
    logic mdrin_q,  mdrin_d;
    logic read_q,   read_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic busy_q,   busy_d;
    logic done_q,   done_d;
    logic err_q,    err_d;

    // State, operation, counter and output registers.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= IDLE;
            op_rd_q  <= 1'b0;
            cnt_q    <= '0;
            marin_q  <= 1'b0;
            mdrin_q  <= 1'b0;
            read_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_rd_q  <= op_rd_d;
            cnt_q    <= cnt_d;
            marin_q  <= marin_d;
            mdrin_q  <= mdrin_d;
            read_q   <= read_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic, plus Moore output decode of the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        op_rd_d  = op_rd_q;
        cnt_d    = '0;
        marin_d  = 1'b0;
        mdrin_d  = 1'b0;
        read_d   = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_rd) begin
                    state_d = LOAD_MAR;
                    op_rd_d = 1'b1;
                end else if (req_wr) begin
                    state_d = LOAD_MAR;
                    op_rd_d = 1'b0;
                end
            end
            LOAD_MAR:    state_d = op_rd_q ? RD_WAIT : WR_LOAD_MDR;
            RD_WAIT,
            WR_WAIT: begin
                // Ready beats the timeout when both happen in the same cycle.
                if (mem_ready) begin
                    state_d = (state_q == RD_WAIT) ? RD_CAPTURE : DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_CAPTURE:  state_d = DONE;
            WR_LOAD_MDR: state_d = WR_WAIT;
            DONE:        state_d = IDLE;
            ERR:         state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        case (state_d)
            LOAD_MAR: marin_d = 1'b1;
            RD_WAIT: begin
                mem_rd_d = 1'b1;
                read_d   = 1'b1;
            end
            RD_CAPTURE: begin
                mem_rd_d = 1'b1;
                read_d   = 1'b1;
                mdrin_d  = 1'b1;
            end
            WR_LOAD_MDR: mdrin_d  = 1'b1;
            WR_WAIT:     mem_wr_d = 1'b1;
            DONE:        done_d   = 1'b1;
            ERR:         err_d    = 1'b1;
            default:     ;
        endcase
    end

    assign MARin  = marin_q;
    assign MDRin  = mdrin_q;
    assign read   = read_q;
    assign mem_rd = mem_rd_q;
    assign mem_wr = mem_wr_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard testbench for mem_access_ctrl. Stimulus pushes expected
// per-access results; a negedge monitor accumulates strobe activity and
// compares against the queue head whenever done or err pulses.
`timescale 1ns/1ps

module tb_mem_access_ctrl;

    logic clock = 1'b0;
    logic clear;
    logic req_rd, req_wr, mem_ready;
    logic MARin, MDRin, read, mem_rd, mem_wr, busy, done, err;

    logic [31:0] mdatain, busmux, mdr;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_done_seen = 0;
    int n_err_seen = 0;
    bit mon_en = 1'b0;

    typedef struct {
        string       nm;
        int          start;
        bit          is_err;
        int          done_rel;
        int          rd_n;
        int          wr_n;
        int          mdr_rel;
        bit          mdr_rd;
        logic [31:0] mdr_val;
    } exp_t;

    exp_t sb[$];

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clock     (clock),
        .clear     (clear),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .mem_ready (mem_ready),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .read      (read),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // MDR register with its input mux, driven by the DUT's enables.
    always @(posedge clock) begin
        if (MDRin) mdr <= read ? mdatain : busmux;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: accumulates per-access activity, checks on done/err.
    initial begin : monitor
        int  mar_c, mdr_c, rd_n, wr_n;
        bit  mdr_rd, idle_chk;
        exp_t e;
        mar_c = -1; mdr_c = -1; rd_n = 0; wr_n = 0; mdr_rd = 0; idle_chk = 0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (busy !== 1'b1) begin
                    mar_c = -1; mdr_c = -1; rd_n = 0; wr_n = 0; mdr_rd = 0;
                end else begin
                    if (MARin && mar_c < 0) mar_c = cyc;
                    if (MDRin && mdr_c < 0) begin
                        mdr_c  = cyc;
                        mdr_rd = read;
                    end
                    rd_n += int'(mem_rd);
                    wr_n += int'(mem_wr);
                end
                if (idle_chk) begin
                    chk("idle_after_end", 32'({MARin, MDRin, read, mem_rd, mem_wr, busy, done, err}), 32'd0);
                    idle_chk = 0;
                end
                if (done === 1'b1 || err === 1'b1) begin
                    chk("done_err_excl", 32'(done & err), 32'd0);
                    if (done) n_done_seen++;
                    if (err)  n_err_seen++;
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", 32'({done, err}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.nm, "_kind_err"}, 32'(err), 32'(e.is_err));
                        chk({e.nm, "_end_cycle"}, 32'(cyc - e.start), 32'(e.done_rel));
                        chk({e.nm, "_marin_cycle"}, 32'((mar_c < 0) ? -1 : mar_c - e.start), 32'd1);
                        chk({e.nm, "_mdrin_cycle"}, 32'((mdr_c < 0) ? -1 : mdr_c - e.start), 32'(e.mdr_rel));
                        if (e.mdr_rel >= 0) chk({e.nm, "_mdr_sel"}, 32'(mdr_rd), 32'(e.mdr_rd));
                        chk({e.nm, "_mem_rd_cycles"}, 32'(rd_n), 32'(e.rd_n));
                        chk({e.nm, "_mem_wr_cycles"}, 32'(wr_n), 32'(e.wr_n));
                        if (!e.is_err) chk({e.nm, "_mdr_value"}, mdr, e.mdr_val);
                    end
                    idle_chk = 1;
                end
            end
        end
    end

    // One access: ready_on is the cycle (relative to the request) from which
    // mem_ready is high, -1 for never; poke is a cycle to pulse req_wr.
    task automatic access(input string nm, input bit rd, input bit wr,
                          input int ready_on, input int poke,
                          input logic [31:0] mdat, input logic [31:0] bus,
                          input bit e_err, input int e_done, input int e_rd,
                          input int e_wr, input int e_mdr, input bit e_mdr_rd,
                          input logic [31:0] e_val);
        exp_t e;
        bit   drained;
        @(negedge clock);
        e.nm = nm; e.start = cyc; e.is_err = e_err; e.done_rel = e_done;
        e.rd_n = e_rd; e.wr_n = e_wr; e.mdr_rel = e_mdr; e.mdr_rd = e_mdr_rd;
        e.mdr_val = e_val;
        sb.push_back(e);
        mdatain   = mdat;
        busmux    = bus;
        req_rd    = rd;
        req_wr    = wr;
        mem_ready = (ready_on == 0);
        drained   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            req_rd    = 1'b0;
            req_wr    = (k == poke);
            mem_ready = (ready_on >= 0 && k >= ready_on);
            if (sb.size() == 0) begin
                drained = 1;
                break;
            end
        end
        req_wr    = 1'b0;
        mem_ready = 1'b0;
        chk({nm, "_completed_in_time"}, 32'(sb.size()), 32'd0);
        if (!drained) sb.delete();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        clear = 1'b0; req_rd = 1'b0; req_wr = 1'b0; mem_ready = 1'b0;
        mdatain = '0; busmux = '0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'({MARin, MDRin, read, mem_rd, mem_wr, busy, done, err}), 32'd0);
        clear = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;

        // Reset in the middle of a read wait.
        req_rd = 1'b1;
        @(negedge clock);
        req_rd = 1'b0;
        @(negedge clock);
        chk("midrd_mem_rd_in_wait", 32'(mem_rd), 32'd1);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("midrd_after_reset", 32'({MARin, MDRin, read, mem_rd, mem_wr, busy, done, err}), 32'd0);
        clear = 1'b1;
        repeat (2) @(negedge clock);

        //     name       rd wr  rdy poke  mdatain        busmux         err end rd wr mdr sel  value
        access("rd_zero",  1, 0,   0, -1, 32'h0000_01A4, 32'hDEAD_0001, 0,  4, 2, 0,  3, 1, 32'h0000_01A4);
        access("wr_wait3", 0, 1,   6, -1, 32'hFFFF_0000, 32'h0000_0045, 0,  7, 0, 4,  2, 0, 32'h0000_0045);
        access("rd_tmo",   1, 0,  -1, -1, 32'h0000_0077, 32'h0000_0000, 1, 17, 15, 0, -1, 0, 32'h0);
        access("rd_and_wr",1, 1,   0, -1, 32'h0000_BEEF, 32'h0000_1111, 0,  4, 2, 0,  3, 1, 32'h0000_BEEF);
        access("rd_busywr",1, 0,   5,  3, 32'h0000_CAFE, 32'h0000_2222, 0,  7, 5, 0,  6, 1, 32'h0000_CAFE);
        access("rd_edge",  1, 0,  16, -1, 32'h0000_5A5A, 32'h0000_0000, 0, 18, 16, 0, 17, 1, 32'h0000_5A5A);
        access("wr_zero",  0, 1,   0, -1, 32'h0000_0000, 32'h1234_5678, 0,  4, 0, 1,  2, 0, 32'h1234_5678);

        repeat (5) @(negedge clock);
        chk("done_pulse_count", 32'(n_done_seen), 32'd6);
        chk("err_pulse_count",  32'(n_err_seen),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
